// File: rtl/ovht_pkg.sv
// Shared definitions for the engine fire-extinguisher discharge sequencer:
// FSM states, engine indices, default timing and the bottle-select helper.
package ovht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_FIRE    = 2'd2,
        ST_RECHECK = 2'd3
    } state_t;

    localparam logic ENG1 = 1'b0;
    localparam logic ENG2 = 1'b1;

    localparam int DEBOUNCE_CYC_DEF = 16;
    localparam int ARM_CYC_DEF      = 64;
    localparam int FIRE_CYC_DEF     = 8;
    localparam int RECHECK_CYC_DEF  = 256;
    localparam int CNT_W_DEF        = 9;

    // Lowest-index bottle still charged (caller guarantees mask != 0).
    function automatic logic first_bottle(input logic [1:0] mask);
        return mask[0] ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/ovht_debounce.sv
// Overheat vote debouncer: confirms after DEBOUNCE_CYC consecutive high cycles.
// Ports: clk, rst_n, i_ovht (raw vote), o_confirmed (level), o_rise (1-cycle pulse).
module ovht_debounce
    import ovht_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ovht,
    output logic o_confirmed,
    output logic o_rise
);

    localparam int W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYC - 1);

    logic [W-1:0] r_cnt;
    logic         r_conf;
    logic         r_rise;
    logic         w_full;

    assign w_full = (r_cnt == LAST);

    // Counter saturates at LAST so confirmed stays up while the vote holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_conf <= 1'b0;
            r_rise <= 1'b0;
        end else if (!i_ovht) begin
            r_cnt  <= '0;
            r_conf <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            if (!w_full) begin
                r_cnt <= r_cnt + W'(1);
            end
            r_conf <= r_conf | w_full;
            r_rise <= w_full & ~r_conf;
        end
    end

    assign o_confirmed = r_conf;
    assign o_rise      = r_rise;

endmodule

// File: rtl/ovht_discharge_sequencer.sv
// Routes two shared extinguisher bottles to engine 1/2 on confirmed overheat
// or pilot request, times the squib pulse and re-fires if the overheat persists.
// Ports: clk, rst_n, eng_ovht[1:0], auto_mode, man_req[1:0] in;
//        squib[1:0], valve[1:0], bottles_left[1:0], busy, no_agent, emergency out.
module ovht_discharge_sequencer
    import ovht_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int ARM_CYC      = ARM_CYC_DEF,
    parameter int FIRE_CYC     = FIRE_CYC_DEF,
    parameter int RECHECK_CYC  = RECHECK_CYC_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eng_ovht,
    input  logic       auto_mode,
    input  logic [1:0] man_req,
    output logic [1:0] squib,
    output logic [1:0] valve,
    output logic [1:0] bottles_left,
    output logic       busy,
    output logic       no_agent,
    output logic       emergency
);

    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYC - 1);
    localparam logic [CNT_W-1:0] FIRE_LAST = CNT_W'(FIRE_CYC - 1);
    localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RECHECK_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_eng;
    logic             r_man;
    logic             r_bottle;
    logic             r_ptr;
    logic [1:0]       r_pend;
    logic [1:0]       r_pman;
    logic [1:0]       r_man_d;
    logic [1:0]       r_squib;
    logic [1:0]       r_valve;
    logic [1:0]       r_bottles;
    logic             r_no_agent;
    logic             r_emerg;

    logic [1:0]       w_conf;
    logic [1:0]       w_rise;
    logic [1:0]       w_man_rise;
    logic [1:0]       w_mask;
    logic [1:0]       w_set;
    logic [1:0]       w_mset;
    logic             w_grant;
    logic             w_gnt_eng;
    logic [1:0]       w_gnt_mask;
    logic             w_abort;

    for (genvar e = 0; e < 2; e++) begin : g_deb
        ovht_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_ovht     (eng_ovht[e]),
            .o_confirmed(w_conf[e]),
            .o_rise     (w_rise[e])
        );
    end

    assign w_man_rise = man_req & ~r_man_d;

    // New requests for the engine being served are absorbed.
    assign w_mask = (r_state != ST_IDLE) ? ~(2'b01 << r_eng) : 2'b11;
    assign w_mset = w_man_rise & w_mask;
    assign w_set  = ((w_rise & {2{auto_mode}}) | w_man_rise) & w_mask;

    assign w_grant    = (r_state == ST_IDLE) && (r_pend != 2'b00);
    assign w_gnt_eng  = (r_pend == 2'b11) ? r_ptr : r_pend[1];
    assign w_gnt_mask = w_grant ? (2'b01 << w_gnt_eng) : 2'b00;

    // Only automatic discharges can be called off during the arm window.
    assign w_abort = !r_man && (!auto_mode || !w_conf[r_eng]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= 2'b00;
            r_pman  <= 2'b00;
            r_man_d <= 2'b00;
            r_ptr   <= ENG1;
            r_emerg <= 1'b0;
        end else begin
            r_pend  <= (r_pend | w_set) & ~w_gnt_mask;
            r_pman  <= (r_pman | w_mset) & ~w_gnt_mask;
            r_man_d <= man_req;
            r_emerg <= |w_conf;
            if (w_grant) begin
                r_ptr <= ~w_gnt_eng;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_eng      <= ENG1;
            r_man      <= 1'b0;
            r_bottle   <= 1'b0;
            r_squib    <= 2'b00;
            r_valve    <= 2'b00;
            r_bottles  <= 2'b11;
            r_no_agent <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        if (r_bottles == 2'b00) begin
                            r_no_agent <= 1'b1;
                        end else begin
                            r_state  <= ST_ARM;
                            r_timer  <= '0;
                            r_eng    <= w_gnt_eng;
                            r_man    <= r_pman[w_gnt_eng];
                            r_bottle <= first_bottle(r_bottles);
                            r_valve  <= 2'b01 << w_gnt_eng;
                        end
                    end
                end
                ST_ARM: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_valve <= 2'b00;
                    end else if (r_man || r_timer == ARM_LAST) begin
                        r_state <= ST_FIRE;
                        r_timer <= '0;
                        r_squib <= 2'b01 << r_bottle;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                ST_FIRE: begin
                    if (r_timer == FIRE_LAST) begin
                        r_state            <= ST_RECHECK;
                        r_timer            <= '0;
                        r_squib            <= 2'b00;
                        r_bottles[r_bottle] <= 1'b0;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                default: begin
                    if (r_timer == RC_LAST) begin
                        r_timer <= '0;
                        if (w_conf[r_eng] && r_bottles != 2'b00) begin
                            r_state  <= ST_ARM;
                            r_man    <= 1'b0;
                            r_bottle <= first_bottle(r_bottles);
                        end else begin
                            r_state <= ST_IDLE;
                            r_valve <= 2'b00;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign squib        = r_squib;
    assign valve        = r_valve;
    assign bottles_left = r_bottles;
    assign busy         = (r_state != ST_IDLE);
    assign no_agent     = r_no_agent;
    assign emergency    = r_emerg;

endmodule
